// File: rtl/mem_port_arbiter.sv
// Shared single-port RAM arbiter for the fetch (IF) and memory (DM) stages.
// One access per cycle. DM has priority, and a starvation guard forces an IF
// grant after STARVE_MAX consecutive DM wins while IF waits. Grants flow
// through a two-stage tag pipeline, so each completion pulses two cycles
// after its grant, in grant order.
//
// tag      | meaning
// ---------+------------------------------------------------
// TAG_NONE | no access issued in that cycle
// TAG_IF   | fetch read issued; capture MemRdata for IF
// TAG_DM_RD| data read issued; capture MemRdata for DM
// TAG_DM_WR| data write issued; pulse DmValid, keep DmRdata
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [DATA_W-1:0] IfRdata,
  output logic              IfValid,
  output logic              IfStall,
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [DATA_W-1:0] DmWdata,
  output logic [DATA_W-1:0] DmRdata,
  output logic              DmValid,
  output logic              DmStall,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF    = 2'd1,
    TAG_DM_RD = 2'd2,
    TAG_DM_WR = 2'd3
  } tag_t;

  logic             grant_if;
  logic             grant_dm;
  logic [CNT_W-1:0] starve_cnt;
  tag_t             tag_issue;
  tag_t             tag_s1;

  // Arbitration: DM wins a conflict unless IF has been starved long enough.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (Rst_n) begin
      if (IfReq && DmReq) begin
        if (starve_cnt == STARVE_LIM) grant_if = 1'b1;
        else                          grant_dm = 1'b1;
      end else begin
        grant_if = IfReq;
        grant_dm = DmReq;
      end
    end
  end

  // Classify this cycle's grant for the completion pipeline.
  always_comb begin
    tag_issue = TAG_NONE;
    if (grant_if)               tag_issue = TAG_IF;
    else if (grant_dm && DmWe)  tag_issue = TAG_DM_WR;
    else if (grant_dm)          tag_issue = TAG_DM_RD;
  end

  assign MemEn    = grant_if | grant_dm;
  assign MemWe    = grant_dm & DmWe;
  assign MemAddr  = grant_if ? IfAddr : (grant_dm ? DmAddr : '0);
  assign MemWdata = (grant_dm && DmWe) ? DmWdata : '0;
  assign IfStall  = IfReq & ~grant_if;
  assign DmStall  = DmReq & ~grant_dm;

  // Count consecutive DM wins while IF is waiting; any IF grant or a cycle
  // without an IF request restarts the count.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      starve_cnt <= '0;
    end else if (!IfReq || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Stage 1 remembers who issued; stage 2 captures RAM data and pulses Valid.
  // Reset flushes both stages so nothing granted before reset completes.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tag_s1  <= TAG_NONE;
      IfValid <= 1'b0;
      DmValid <= 1'b0;
      IfRdata <= '0;
      DmRdata <= '0;
    end else begin
      tag_s1  <= tag_issue;
      IfValid <= (tag_s1 == TAG_IF);
      DmValid <= (tag_s1 == TAG_DM_RD) || (tag_s1 == TAG_DM_WR);
      if (tag_s1 == TAG_IF)    IfRdata <= MemRdata;
      if (tag_s1 == TAG_DM_RD) DmRdata <= MemRdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural RAM, directed scenarios, then
// randomized traffic checked cycle by cycle against a queue-based model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              IfReq;
  logic [ADDR_W-1:0] IfAddr;
  logic [DATA_W-1:0] IfRdata;
  logic              IfValid;
  logic              IfStall;
  logic              DmReq;
  logic              DmWe;
  logic [ADDR_W-1:0] DmAddr;
  logic [DATA_W-1:0] DmWdata;
  logic [DATA_W-1:0] DmRdata;
  logic              DmValid;
  logic              DmStall;
  logic              MemEn;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfValid(IfValid), .IfStall(IfStall),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata),
    .DmRdata(DmRdata), .DmValid(DmValid), .DmStall(DmStall),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata)
  );

  always #5 Clk = ~Clk;

  // Single-port synchronous RAM, write-first, one-cycle read latency.
  logic [DATA_W-1:0] ram [256];
  always @(posedge Clk) begin
    if (MemEn) begin
      if (MemWe) begin
        ram[MemAddr] <= MemWdata;
        MemRdata     <= MemWdata;
      end else begin
        MemRdata <= ram[MemAddr];
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          is_if;
    bit          is_wr;
    logic [31:0] data;
  } comp_t;

  comp_t       q[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          if_waited = 0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;
  bit          last_gi, last_gd;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: evaluate the model at the falling edge, compare every
  // output, record the grant, then advance past the next rising edge.
  task automatic step();
    bit          gi, gd, exp_iv, exp_dv;
    comp_t       c;
    logic [31:0] exp_addr, exp_wd;
    @(negedge Clk);
    gi = 0;
    gd = 0;
    if (Rst_n) begin
      if (IfReq && DmReq) begin
        if (if_waited >= STARVE_MAX) gi = 1;
        else                         gd = 1;
      end else begin
        gi = IfReq;
        gd = DmReq;
      end
    end
    exp_addr = gi ? 32'(IfAddr) : (gd ? 32'(DmAddr) : 32'd0);
    exp_wd   = (gd && DmWe) ? DmWdata : 32'd0;
    chk("mem_en",    MemEn,    gi | gd);
    chk("mem_we",    MemWe,    gd & DmWe);
    chk("mem_addr",  MemAddr,  exp_addr);
    chk("mem_wdata", MemWdata, exp_wd);
    chk("if_stall",  IfStall,  IfReq & ~gi);
    chk("dm_stall",  DmStall,  DmReq & ~gd);

    exp_iv = 0;
    exp_dv = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      c = q.pop_front();
      if (c.is_if) begin
        exp_iv    = 1;
        exp_if_rd = c.data;
      end else begin
        exp_dv = 1;
        if (!c.is_wr) exp_dm_rd = c.data;
      end
    end
    chk("if_valid", IfValid, exp_iv);
    chk("dm_valid", DmValid, exp_dv);
    chk("if_rdata", IfRdata, exp_if_rd);
    chk("dm_rdata", DmRdata, exp_dm_rd);

    if (gi) q.push_back('{cyc + 2, 1'b1, 1'b0, ref_mem[IfAddr]});
    if (gd) begin
      if (DmWe) begin
        ref_mem[DmAddr] = DmWdata;
        q.push_back('{cyc + 2, 1'b0, 1'b1, 32'd0});
      end else begin
        q.push_back('{cyc + 2, 1'b0, 1'b0, ref_mem[DmAddr]});
      end
    end
    if (!IfReq || gi)                        if_waited = 0;
    else if (gd && if_waited < STARVE_MAX)   if_waited = if_waited + 1;

    if (!Rst_n) begin
      q.delete();
      exp_if_rd = '0;
      exp_dm_rd = '0;
      if_waited = 0;
    end
    last_gi = gi;
    last_gd = gd;
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
      ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    end
    ram[4]     = 32'h2002000A;
    ref_mem[4] = 32'h2002000A;

    // Reset held two cycles with a fetch request pending.
    Rst_n = 0; IfReq = 1; IfAddr = 8'd3;
    DmReq = 0; DmWe = 0; DmAddr = '0; DmWdata = '0;
    @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_mem_en", MemEn, 1'b0);
      chk("rst_if_stall", IfStall, 1'b1);
      chk("rst_if_valid", IfValid, 1'b0);
      chk("rst_if_rdata", IfRdata, 32'd0);
      step();
    end
    Rst_n = 1; IfReq = 0;
    step();

    // Fetch alone from address 4.
    IfReq = 1; IfAddr = 8'd4;
    #1;
    chk("if_only_en", MemEn, 1'b1);
    chk("if_only_addr", MemAddr, 32'd4);
    chk("if_only_stall", IfStall, 1'b0);
    step();
    IfReq = 0;
    step();
    #1;
    chk("if_only_valid", IfValid, 1'b1);
    chk("if_only_rdata", IfRdata, 32'h2002000A);
    step();

    // DM write then read of address 9, back to back.
    DmReq = 1; DmWe = 1; DmAddr = 8'd9; DmWdata = 32'hDEADBEEF;
    #1;
    chk("wr_mem_we", MemWe, 1'b1);
    step();
    DmWe = 0; DmWdata = '0;
    #1;
    chk("rd_mem_we", MemWe, 1'b0);
    step();
    DmReq = 0;
    #1;
    chk("wr_dm_valid", DmValid, 1'b1);
    step();
    #1;
    chk("rd_dm_valid", DmValid, 1'b1);
    chk("rd_dm_rdata", DmRdata, 32'hDEADBEEF);
    step();
    step();

    // Sustained conflict: DM,DM,DM,IF,DM.
    IfReq = 1; IfAddr = 8'd1; DmReq = 1; DmWe = 0; DmAddr = 8'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("starve_if_stall", IfStall, (k == 3) ? 1'b0 : 1'b1);
      chk("starve_addr", MemAddr, (k == 3) ? 32'd1 : 32'd2);
      step();
    end
    IfReq = 0; DmReq = 0;
    #1;
    chk("starve_if_valid", IfValid, 1'b1);
    step();
    step();
    step();

    // Reset the cycle after an IF grant: the fetch must never complete.
    IfReq = 1; IfAddr = 8'd7;
    step();
    IfReq = 0; Rst_n = 0;
    step();
    Rst_n = 1;
    #1;
    chk("flush_n2", IfValid, 1'b0);
    step();
    #1;
    chk("flush_n3", IfValid, 1'b0);
    step();

    // Random traffic; requesters hold until granted, occasionally give up,
    // and reset is pulsed now and then.
    for (int n = 0; n < 10000; n++) begin
      if (!IfReq || last_gi) begin
        IfReq  = ($urandom % 3) != 0;
        IfAddr = ADDR_W'($urandom_range(0, 15));
      end else if (($urandom % 16) == 0) begin
        IfReq = 0;
      end
      if (!DmReq || last_gd) begin
        DmReq   = ($urandom % 3) != 0;
        DmWe    = $urandom % 2;
        DmAddr  = ADDR_W'($urandom_range(0, 15));
        DmWdata = $urandom;
      end else if (($urandom % 16) == 0) begin
        DmReq = 0;
      end
      Rst_n = (($urandom % 500) != 0);
      step();
    end
    Rst_n = 1; IfReq = 0; DmReq = 0;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
